// File: rtl/frame_line_reader.sv
// Bus-master DMA that copies grayscale pixel words from system memory into a
// 256-word line buffer, which software reads back through custom instructions.
module frame_line_reader #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         maxBurstWords       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        requestBus,
    input  logic        busGrant,
    output logic        beginTransactionOut,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic        readNotWriteOut,
    output logic [7:0]  burstSizeOut,
    output logic        endTransactionOut,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn
);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST_BUS,
        INIT_BURST,
        RECEIVE,
        ABORT
    } state_t;

    localparam logic [8:0] MAX_BURST = 9'(maxBurstWords);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] src_addr_reg;
    logic [8:0]  remaining_reg;
    logic [8:0]  in_burst_reg;
    logic [7:0]  write_ptr_reg;
    logic        done_flag_reg;
    logic        error_flag_reg;
    logic [31:0] line_buffer [0:255];

    logic        is_my_ci;
    logic [2:0]  cmd;
    logic        busy;
    logic [8:0]  count_clamped;
    logic        start_accept;
    logic        addr_write;
    logic        flag_clear;
    logic [8:0]  burst_words;
    logic [8:0]  burst_m1;
    logic        word_accept;
    logic [8:0]  remaining_after;
    logic        unused_bits;

    assign is_my_ci      = ciStart & ciCke & (ciN == customInstructionId);
    assign cmd           = ciValueA[2:0];
    assign busy          = (state_reg != IDLE);
    assign count_clamped = (ciValueB[8:0] > 9'd256) ? 9'd256 : ciValueB[8:0];
    assign start_accept  = is_my_ci && (cmd == 3'd2) && !busy && (ciValueB[8:0] != 9'd0);
    assign addr_write    = is_my_ci && (cmd == 3'd1) && !busy;
    assign flag_clear    = is_my_ci && (cmd == 3'd5);
    assign burst_words   = (remaining_reg > MAX_BURST) ? MAX_BURST : remaining_reg;
    assign burst_m1      = burst_words - 9'd1;

    // A word is kept only while the programmed transfer still has room; an
    // error in the same cycle discards it.
    assign word_accept = (state_reg == RECEIVE) && dataValidIn && !busErrorIn &&
                         ((remaining_reg != 9'd0) || (in_burst_reg != 9'd0));

    // Surplus words beyond the current burst are charged to the remaining count.
    assign remaining_after = (word_accept && (in_burst_reg == 9'd0)) ?
                             (remaining_reg - 9'd1) : remaining_reg;

    assign unused_bits = ^{ciValueA[31:3], burst_m1[8]};

    assign ciDone     = is_my_ci;
    assign requestBus = (state_reg == REQUEST_BUS);

    always_comb begin
        ciResult = 32'd0;
        if (is_my_ci) begin
            case (cmd)
                3'd0:    ciResult = {29'd0, error_flag_reg, done_flag_reg, busy};
                3'd3:    ciResult = line_buffer[ciValueB[7:0]];
                3'd4:    ciResult = src_addr_reg;
                default: ciResult = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_accept) begin
                    state_next = REQUEST_BUS;
                end
            end
            REQUEST_BUS: begin
                if (busGrant) begin
                    state_next = INIT_BURST;
                end
            end
            INIT_BURST: begin
                state_next = RECEIVE;
            end
            RECEIVE: begin
                if (busErrorIn) begin
                    state_next = ABORT;
                end else if (endTransactionIn) begin
                    state_next = (remaining_after != 9'd0) ? REQUEST_BUS : IDLE;
                end
            end
            ABORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_addr_reg        <= 32'd0;
            remaining_reg       <= 9'd0;
            in_burst_reg        <= 9'd0;
            write_ptr_reg       <= 8'd0;
            done_flag_reg       <= 1'b0;
            error_flag_reg      <= 1'b0;
            beginTransactionOut <= 1'b0;
            addressDataOut      <= 32'd0;
            byteEnablesOut      <= 4'd0;
            readNotWriteOut     <= 1'b0;
            burstSizeOut        <= 8'd0;
            endTransactionOut   <= 1'b0;
        end else begin
            // Bus-side strobes are single-cycle unless re-asserted below.
            beginTransactionOut <= 1'b0;
            addressDataOut      <= 32'd0;
            byteEnablesOut      <= 4'd0;
            readNotWriteOut     <= 1'b0;
            burstSizeOut        <= 8'd0;
            endTransactionOut   <= 1'b0;

            if (flag_clear) begin
                done_flag_reg  <= 1'b0;
                error_flag_reg <= 1'b0;
            end
            if (addr_write) begin
                src_addr_reg <= {ciValueB[31:2], 2'b00};
            end
            if (start_accept) begin
                remaining_reg  <= count_clamped;
                in_burst_reg   <= 9'd0;
                write_ptr_reg  <= 8'd0;
                done_flag_reg  <= 1'b0;
                error_flag_reg <= 1'b0;
            end

            case (state_reg)
                INIT_BURST: begin
                    beginTransactionOut <= 1'b1;
                    addressDataOut      <= src_addr_reg;
                    byteEnablesOut      <= 4'hF;
                    readNotWriteOut     <= 1'b1;
                    burstSizeOut        <= burst_m1[7:0];
                    in_burst_reg        <= burst_words;
                    remaining_reg       <= remaining_reg - burst_words;
                end
                RECEIVE: begin
                    if (word_accept) begin
                        write_ptr_reg <= write_ptr_reg + 8'd1;
                        src_addr_reg  <= src_addr_reg + 32'd4;
                        if (in_burst_reg != 9'd0) begin
                            in_burst_reg <= in_burst_reg - 9'd1;
                        end else begin
                            remaining_reg <= remaining_reg - 9'd1;
                        end
                    end
                    if (!busErrorIn && endTransactionIn && (remaining_after == 9'd0)) begin
                        done_flag_reg <= 1'b1;
                    end
                end
                ABORT: begin
                    endTransactionOut <= 1'b1;
                    error_flag_reg    <= 1'b1;
                    remaining_reg     <= 9'd0;
                    in_burst_reg      <= 9'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer contents survive reset; reads are combinational so a same-cycle
    // write is seen by software only on the following cycle.
    always_ff @(posedge clock) begin
        if (word_accept) begin
            line_buffer[write_ptr_reg] <= addressDataIn;
        end
    end

endmodule
